// File: rtl/pred_pkg.sv
// Shared predictor definitions: controller states, default counter constants
// and the saturating-counter update used by the PHT update path.
package pred_pkg;

    localparam int CNT_WIDTH_DEF = 2;
    localparam int CNT_MAX       = (1 << CNT_WIDTH_DEF) - 1;
    localparam int CNT_INIT      = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ctrl_state_t;

    // Saturating up/down step; cnt_max is passed in so any counter width works.
    function automatic int unsigned sat_update(int unsigned cnt, logic taken,
                                               int unsigned cnt_max);
        if (taken) begin
            return (cnt >= cnt_max) ? cnt_max : cnt + 1;
        end
        return (cnt == 0) ? 0 : cnt - 1;
    endfunction

endpackage

// File: rtl/pht_update_ctrl_if.sv
// Branch-resolution bus: two resolution slots per cycle (slot 1 older) plus
// the shared ready back-pressure.
interface pht_update_ctrl_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int CNT_WIDTH   = 2
);
    logic                   res_valid1;
    logic [INDEX_WIDTH-1:0] res_index1;
    logic                   res_taken1;
    logic [CNT_WIDTH-1:0]   res_count1;
    logic                   res_valid2;
    logic [INDEX_WIDTH-1:0] res_index2;
    logic                   res_taken2;
    logic [CNT_WIDTH-1:0]   res_count2;
    logic                   res_ready;

    modport master (
        output res_valid1, res_index1, res_taken1, res_count1,
        output res_valid2, res_index2, res_taken2, res_count2,
        input  res_ready
    );

    modport slave (
        input  res_valid1, res_index1, res_taken1, res_count1,
        input  res_valid2, res_index2, res_taken2, res_count2,
        output res_ready
    );
endinterface

// File: rtl/pht_update_queue.sv
// Circular update queue: 2-wide enqueue, 0..2 dequeue per cycle, and
// newest-first index lookups used for forwarding and base selection.
module pht_update_queue #(
    parameter int INDEX_WIDTH = 8,
    parameter int CNT_WIDTH   = 2,
    parameter int QDEPTH      = 4,
    parameter int NUM_LOOKUP  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       enq_en1,
    input  logic [INDEX_WIDTH-1:0]     enq_index1,
    input  logic [CNT_WIDTH-1:0]       enq_count1,
    input  logic                       enq_en2,
    input  logic [INDEX_WIDTH-1:0]     enq_index2,
    input  logic [CNT_WIDTH-1:0]       enq_count2,
    input  logic [1:0]                 deq_num,
    output logic [$clog2(QDEPTH):0]    occupancy,
    output logic [INDEX_WIDTH-1:0]     head_index0,
    output logic [CNT_WIDTH-1:0]       head_count0,
    output logic [INDEX_WIDTH-1:0]     head_index1,
    output logic [CNT_WIDTH-1:0]       head_count1,
    input  logic [INDEX_WIDTH-1:0]     lk_index [NUM_LOOKUP],
    output logic                       lk_hit   [NUM_LOOKUP],
    output logic [CNT_WIDTH-1:0]       lk_count [NUM_LOOKUP]
);
    localparam int PW = $clog2(QDEPTH);
    localparam int OW = PW + 1;

    logic [INDEX_WIDTH-1:0] ent_index_reg [QDEPTH];
    logic [CNT_WIDTH-1:0]   ent_count_reg [QDEPTH];
    logic [PW-1:0]          rd_ptr_reg, wr_ptr_reg;
    logic [OW-1:0]          occ_reg;
    logic [OW-1:0]          enq_num;

    assign enq_num     = OW'(enq_en1) + OW'(enq_en2);
    assign occupancy   = occ_reg;
    assign head_index0 = ent_index_reg[rd_ptr_reg];
    assign head_count0 = ent_count_reg[rd_ptr_reg];
    assign head_index1 = ent_index_reg[rd_ptr_reg + PW'(1)];
    assign head_count1 = ent_count_reg[rd_ptr_reg + PW'(1)];

    // Pointer/occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + PW'(deq_num);
            wr_ptr_reg <= wr_ptr_reg + PW'(enq_num);
            occ_reg    <= occ_reg + enq_num - OW'(deq_num);
        end
    end

    // Entry storage: a lone slot-2 enqueue is packed into the first free entry.
    always_ff @(posedge clk) begin
        if (enq_en1 || enq_en2) begin
            ent_index_reg[wr_ptr_reg] <= enq_en1 ? enq_index1 : enq_index2;
            ent_count_reg[wr_ptr_reg] <= enq_en1 ? enq_count1 : enq_count2;
        end
        if (enq_en1 && enq_en2) begin
            ent_index_reg[wr_ptr_reg + PW'(1)] <= enq_index2;
            ent_count_reg[wr_ptr_reg + PW'(1)] <= enq_count2;
        end
    end

    for (genvar gi = 0; gi < NUM_LOOKUP; gi++) begin : g_lookup
        logic                 hit;
        logic [CNT_WIDTH-1:0] cnt;
        // Scan oldest to newest so the newest matching entry wins.
        always_comb begin
            hit = 1'b0;
            cnt = '0;
            for (int j = 0; j < QDEPTH; j++) begin
                if (j < int'(occ_reg) &&
                    ent_index_reg[rd_ptr_reg + PW'(j)] == lk_index[gi]) begin
                    hit = 1'b1;
                    cnt = ent_count_reg[rd_ptr_reg + PW'(j)];
                end
            end
        end
        assign lk_hit[gi]   = hit;
        assign lk_count[gi] = cnt;
    end
endmodule

// File: rtl/pht_update_ctrl.sv
// PHT write sequencer: turns branch resolutions into saturating-counter
// updates, queues and drains them two per cycle, forwards pending counters to
// the fetch read, and runs a full-table clear sweep on request.
module pht_update_ctrl #(
    parameter int INDEX_WIDTH = 8,
    parameter int CNT_WIDTH   = 2,
    parameter int CNT_INIT    = 0,
    parameter int QDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pht_update_ctrl_if.slave       res,
    input  logic                   clear_req,
    output logic                   clear_busy,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    input  logic [CNT_WIDTH-1:0]   pht_rd_count,
    output logic [CNT_WIDTH-1:0]   pred_count,
    output logic                   pred_taken,
    output logic                   pht_wr_en1,
    output logic [INDEX_WIDTH-1:0] pht_wr_index1,
    output logic [CNT_WIDTH-1:0]   pht_wr_count1,
    output logic                   pht_wr_en2,
    output logic [INDEX_WIDTH-1:0] pht_wr_index2,
    output logic [CNT_WIDTH-1:0]   pht_wr_count2,
    output logic                   overflow_err
);
    import pred_pkg::*;

    localparam int          OW      = $clog2(QDEPTH) + 1;
    localparam int unsigned CNT_TOP = (1 << CNT_WIDTH) - 1;

    ctrl_state_t              state_reg, state_next;
    logic [INDEX_WIDTH-2:0]   sweep_reg, sweep_next;
    logic                     ovf_reg, ovf_next;

    logic [OW-1:0]            occ;
    logic [INDEX_WIDTH-1:0]   head_index0, head_index1;
    logic [CNT_WIDTH-1:0]     head_count0, head_count1;
    logic [INDEX_WIDTH-1:0]   lk_index [3];
    logic                     lk_hit   [3];
    logic [CNT_WIDTH-1:0]     lk_count [3];
    logic                     acc1, acc2, flush;
    logic [1:0]               deq_num;
    logic [CNT_WIDTH-1:0]     base1, base2, new1, new2;

    // Lookup 0 serves fetch forwarding, lookups 1/2 supply slot bases.
    assign lk_index[0] = rd_index;
    assign lk_index[1] = res.res_index1;
    assign lk_index[2] = res.res_index2;

    assign res.res_ready = (state_reg == IDLE) && (occ <= OW'(QDEPTH - 2));
    assign acc1          = res.res_valid1 && res.res_ready;
    assign acc2          = res.res_valid2 && res.res_ready;
    assign flush         = clear_req;
    assign clear_busy    = (state_reg == CLEAR);
    assign overflow_err  = ovf_reg;
    assign pred_taken    = pred_count[CNT_WIDTH-1];

    pht_update_queue #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .QDEPTH      (QDEPTH),
        .NUM_LOOKUP  (3)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .enq_en1     (acc1),
        .enq_index1  (res.res_index1),
        .enq_count1  (new1),
        .enq_en2     (acc2),
        .enq_index2  (res.res_index2),
        .enq_count2  (new2),
        .deq_num     (deq_num),
        .occupancy   (occ),
        .head_index0 (head_index0),
        .head_count0 (head_count0),
        .head_index1 (head_index1),
        .head_count1 (head_count1),
        .lk_index    (lk_index),
        .lk_hit      (lk_hit),
        .lk_count    (lk_count)
    );

    // Update arithmetic: pending queue value beats the prediction-time sample,
    // and slot 2 chains off slot 1 when both hit the same index.
    always_comb begin
        base1 = lk_hit[1] ? lk_count[1] : res.res_count1;
        new1  = CNT_WIDTH'(sat_update(32'(base1), res.res_taken1, CNT_TOP));
        if (res.res_valid1 && (res.res_index2 == res.res_index1)) begin
            base2 = new1;
        end else begin
            base2 = lk_hit[2] ? lk_count[2] : res.res_count2;
        end
        new2 = CNT_WIDTH'(sat_update(32'(base2), res.res_taken2, CNT_TOP));
    end

    // State, sweep pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sweep_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state logic plus write-port, dequeue and forwarding muxes.
    always_comb begin
        state_next    = state_reg;
        sweep_next    = sweep_reg;
        ovf_next      = ovf_reg | ((res.res_valid1 | res.res_valid2) & ~res.res_ready);
        deq_num       = 2'd0;
        pht_wr_en1    = 1'b0;
        pht_wr_index1 = head_index0;
        pht_wr_count1 = head_count0;
        pht_wr_en2    = 1'b0;
        pht_wr_index2 = head_index1;
        pht_wr_count2 = head_count1;
        pred_count    = lk_hit[0] ? lk_count[0] : pht_rd_count;

        case (state_reg)
            IDLE: begin
                if (occ >= OW'(2)) begin
                    deq_num    = 2'd2;
                    pht_wr_en1 = (head_index0 != head_index1);
                    pht_wr_en2 = 1'b1;
                end else if (occ == OW'(1)) begin
                    deq_num    = 2'd1;
                    pht_wr_en1 = 1'b1;
                end
                if (clear_req) begin
                    state_next = CLEAR;
                    sweep_next = '0;
                end
            end
            CLEAR: begin
                pht_wr_en1    = 1'b1;
                pht_wr_index1 = {sweep_reg, 1'b0};
                pht_wr_count1 = CNT_WIDTH'(CNT_INIT);
                pht_wr_en2    = 1'b1;
                pht_wr_index2 = {sweep_reg, 1'b1};
                pht_wr_count2 = CNT_WIDTH'(CNT_INIT);
                pred_count    = CNT_WIDTH'(CNT_INIT);
                if (clear_req) begin
                    sweep_next = '0;
                end else if (sweep_reg == '1) begin
                    state_next = IDLE;
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pht_update_ctrl.sv
// Bench for pht_update_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based model of pending PHT updates.
module tb_pht_update_ctrl;
    localparam int IW    = 8;
    localparam int CW    = 2;
    localparam int QD    = 4;
    localparam int DEPTH = 1 << IW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req = 1'b0;
    logic          clear_busy;
    logic [IW-1:0] rd_index = '0;
    logic [CW-1:0] pht_rd_count;
    logic [CW-1:0] pred_count;
    logic          pred_taken;
    logic          pht_wr_en1, pht_wr_en2;
    logic [IW-1:0] pht_wr_index1, pht_wr_index2;
    logic [CW-1:0] pht_wr_count1, pht_wr_count2;
    logic          overflow_err;

    pht_update_ctrl_if #(.INDEX_WIDTH(IW), .CNT_WIDTH(CW)) rif ();

    pht_update_ctrl #(.INDEX_WIDTH(IW), .CNT_WIDTH(CW), .CNT_INIT(0), .QDEPTH(QD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .res           (rif),
        .clear_req     (clear_req),
        .clear_busy    (clear_busy),
        .rd_index      (rd_index),
        .pht_rd_count  (pht_rd_count),
        .pred_count    (pred_count),
        .pred_taken    (pred_taken),
        .pht_wr_en1    (pht_wr_en1),
        .pht_wr_index1 (pht_wr_index1),
        .pht_wr_count1 (pht_wr_count1),
        .pht_wr_en2    (pht_wr_en2),
        .pht_wr_index2 (pht_wr_index2),
        .pht_wr_count2 (pht_wr_count2),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    // The PHT itself: reinitialises to 2 on reset, port 2 written last so it wins.
    logic [CW-1:0] pht [DEPTH];
    assign pht_rd_count = pht[rd_index];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pht[i] <= 2'd2;
        end else begin
            if (pht_wr_en1) pht[pht_wr_index1] <= pht_wr_count1;
            if (pht_wr_en2) pht[pht_wr_index2] <= pht_wr_count2;
        end
    end

    typedef struct {
        int idx;
        int cnt;
    } upd_t;

    upd_t pend[$];
    bit   m_busy;
    int   m_k;
    bit   m_ovf;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int b, input bit t);
        if (t) return (b + 1 > CMAX) ? CMAX : b + 1;
        return (b - 1 < 0) ? 0 : b - 1;
    endfunction

    // Newest pending value for an index, if any.
    function automatic bit newest(input int idx, output int cnt);
        cnt = 0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].idx == idx) begin
                cnt = pend[i].cnt;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_busy = 1'b0;
        m_k    = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rif.res_valid1 = 1'b0;
        rif.res_valid2 = 1'b0;
        clear_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs, check every output against the model, advance.
    task automatic step(input bit v1, input int i1, input bit t1, input int c1,
                        input bit v2, input int i2, input bit t2, input int c2,
                        input bit clr, input int rdi);
        bit e1, e2, rdy, f;
        int x1, y1, x2, y2, ep, b, n1, n2, fc;
        rif.res_valid1 = v1; rif.res_index1 = IW'(i1); rif.res_taken1 = t1; rif.res_count1 = CW'(c1);
        rif.res_valid2 = v2; rif.res_index2 = IW'(i2); rif.res_taken2 = t2; rif.res_count2 = CW'(c2);
        clear_req = clr;
        rd_index  = IW'(rdi);
        #1;
        e1 = 0; e2 = 0; x1 = 0; y1 = 0; x2 = 0; y2 = 0; n1 = 0; n2 = 0;
        if (m_busy) begin
            rdy = 0; ep = 0;
            e1 = 1; x1 = 2 * m_k;     y1 = 0;
            e2 = 1; x2 = 2 * m_k + 1; y2 = 0;
        end else begin
            rdy = (QD - pend.size()) >= 2;
            ep  = newest(rdi, fc) ? fc : int'(pht[rdi]);
            if (pend.size() >= 2) begin
                e2 = 1; x2 = pend[1].idx; y2 = pend[1].cnt;
                if (pend[0].idx != pend[1].idx) begin
                    e1 = 1; x1 = pend[0].idx; y1 = pend[0].cnt;
                end
            end else if (pend.size() == 1) begin
                e1 = 1; x1 = pend[0].idx; y1 = pend[0].cnt;
            end
        end
        check_val("res_ready", rif.res_ready, rdy);
        check_val("clear_busy", clear_busy, m_busy);
        check_val("pred_count", pred_count, ep);
        check_val("pred_taken", pred_taken, (ep >> (CW - 1)) & 1);
        check_val("overflow_err", overflow_err, m_ovf);
        check_val("wr_en1", pht_wr_en1, e1);
        check_val("wr_en2", pht_wr_en2, e2);
        if (e1) begin
            check_val("wr_index1", pht_wr_index1, x1);
            check_val("wr_count1", pht_wr_count1, y1);
        end
        if (e2) begin
            check_val("wr_index2", pht_wr_index2, x2);
            check_val("wr_count2", pht_wr_count2, y2);
        end
        // Advance the model to the post-edge state.
        if ((v1 || v2) && !rdy) m_ovf = 1'b1;
        if (!m_busy) begin
            if (v1) begin
                f  = newest(i1, fc);
                n1 = sat(f ? fc : c1, t1);
            end
            if (v2) begin
                if (v1 && i2 == i1) b = n1;
                else begin
                    f = newest(i2, fc);
                    b = f ? fc : c2;
                end
                n2 = sat(b, t2);
            end
            for (int k = 0; k < 2 && pend.size() > 0; k++) void'(pend.pop_front());
            if (v1) pend.push_back('{idx: i1, cnt: n1});
            if (v2) pend.push_back('{idx: i2, cnt: n2});
            if (clr) begin
                m_busy = 1'b1;
                m_k    = 0;
                pend.delete();
            end
        end else begin
            if (clr) m_k = 0;
            else if (m_k == DEPTH / 2 - 1) begin
                m_busy = 1'b0;
                m_k    = 0;
            end else m_k++;
        end
        @(posedge clk);
        #1;
        $display("cycle t=%0t v=%0b%0b idx=%0d/%0d clr=%0b rd=%0d wr=%0b%0b busy=%0b",
                 $time, v1, v2, i1, i2, clr, rdi, pht_wr_en1, pht_wr_en2, clear_busy);
    endtask

    task automatic idle(input int rdi);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdi);
    endtask

    int busy_cycles;

    initial begin
        rif.res_valid1 = 1'b0; rif.res_index1 = '0; rif.res_taken1 = 1'b0; rif.res_count1 = '0;
        rif.res_valid2 = 1'b0; rif.res_index2 = '0; rif.res_taken2 = 1'b0; rif.res_count2 = '0;
        model_reset();
        do_reset();

        // 1: quiet after reset, forwarding falls through to the PHT
        check_val("t1_wr_en1", pht_wr_en1, 0);
        check_val("t1_wr_en2", pht_wr_en2, 0);
        check_val("t1_ready", rif.res_ready, 1);
        check_val("t1_pred", pred_count, 2);
        idle(0);

        // 2: saturating increment and decrement-at-zero
        step(1, 5, 1, 3, 1, 9, 0, 0, 0, 5);
        check_val("t2_wr1_idx", pht_wr_index1, 5);
        check_val("t2_wr1_cnt", pht_wr_count1, 3);
        check_val("t2_wr2_idx", pht_wr_index2, 9);
        check_val("t2_wr2_cnt", pht_wr_count2, 0);
        check_val("t2_pred_fwd", pred_count, 3);
        idle(5);

        // 3: both slots on one index chain, only port 2 writes
        step(1, 7, 1, 1, 1, 7, 1, 1, 0, 7);
        check_val("t3_wr_en1", pht_wr_en1, 0);
        check_val("t3_wr2_cnt", pht_wr_count2, 3);
        check_val("t3_pred_fwd", pred_count, 3);
        idle(7);

        // 4: back-to-back on index 4 with a stale sampled base
        step(1, 4, 1, 1, 0, 0, 0, 0, 0, 4);
        check_val("t4_first_cnt", pht_wr_count1, 2);
        step(1, 4, 1, 1, 0, 0, 0, 0, 0, 4);
        check_val("t4_second_cnt", pht_wr_count1, 3);
        idle(4);
        check_val("t4_pht_final", pred_count, 3);

        // 5: clear with entries being enqueued; they must be discarded
        step(1, 12, 1, 1, 1, 13, 1, 1, 0, 12);
        step(1, 12, 1, 2, 1, 13, 1, 2, 1, 12);
        busy_cycles = 0;
        for (int i = 0; i < 140; i++) begin
            if (clear_busy) busy_cycles++;
            if (i == 0) step(1, 3, 1, 1, 0, 0, 0, 0, 0, 12);
            else if (i < 100) step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7),
                                   $urandom_range(0, 1), $urandom_range(0, 3), 0, 12);
            else idle(12);
        end
        check_val("t5_busy_cycles", busy_cycles, DEPTH / 2);
        check_val("t5_pht12", pht[12], 0);
        check_val("t5_pht255", pht[255], 0);
        check_val("t5_overflow", overflow_err, 1);

        // 6: restart mid-sweep, then reset mid-sweep
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, i, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) idle(1);
        do_reset();
        check_val("t6_wr_en1", pht_wr_en1, 0);
        check_val("t6_wr_en2", pht_wr_en2, 0);
        check_val("t6_overflow", overflow_err, 0);
        check_val("t6_busy", clear_busy, 0);
        check_val("t6_ready", rif.res_ready, 1);

        // Random traffic over a small index range to provoke collisions
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                 ($urandom_range(0, 199) == 0), $urandom_range(0, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
